// File: rtl/exc_check_requester.sv
// rtl/exc_check_requester.sv - FIFO-buffered initiator for the FP exception-check handshake.
// Optional ACK watchdog with sticky timeout_flag port when TIMEOUT_EN is defined.
module exc_check_requester #(
  parameter int DEPTH          = 4,
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic [31:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [31:0]      chk_data,
  output logic             chk_valid,
  input  logic             chk_ack,
  input  logic [2:0]       chk_exc,
  output logic [31:0]      res_data,
  output logic [2:0]       res_exc,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] inf_count,
  output logic [CNT_W-1:0] nan_count,
  output logic             busy
`ifdef TIMEOUT_EN
  ,
  output logic             timeout_flag
`endif
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t            state_q, state_d;
  logic [31:0]       mem_q [DEPTH];
  logic [31:0]       mem_d [DEPTH];
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [31:0]       chk_data_q, chk_data_d;
  logic              chk_valid_q, chk_valid_d;
  logic [31:0]       res_data_q, res_data_d;
  logic [2:0]        res_exc_q, res_exc_d;
  logic              res_valid_q, res_valid_d;
  logic [CNT_W-1:0]  inf_q, inf_d;
  logic [CNT_W-1:0]  nan_q, nan_d;
  logic              full, empty, push;
  logic              capture;
  logic [2:0]        cap_code;

`ifdef TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0]     tmo_cnt_q, tmo_cnt_d;
  logic              timeout_flag_q, timeout_flag_d;
`endif

  // Pointers carry one extra wrap bit so full and empty stay distinguishable.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push  = in_valid && !full;

  always_comb begin
    state_d     = state_q;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    chk_data_d  = chk_data_q;
    chk_valid_d = chk_valid_q;
    res_data_d  = res_data_q;
    res_exc_d   = res_exc_q;
    res_valid_d = res_valid_q;
    inf_d       = inf_q;
    nan_d       = nan_q;
    capture     = 1'b0;
    cap_code    = chk_exc;
`ifdef TIMEOUT_EN
    tmo_cnt_d      = (state_q == WAIT) ? tmo_cnt_q + 1'b1 : '0;
    timeout_flag_d = timeout_flag_q;
`endif

    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = in_data;
      wr_ptr_d                = wr_ptr_q + 1'b1;
    end

    if (res_valid_q && res_ready) begin
      res_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (!empty && !res_valid_q) begin
          chk_data_d  = mem_q[rd_ptr_q[AW-1:0]];
          chk_valid_d = 1'b1;
          rd_ptr_d    = rd_ptr_q + 1'b1;
          state_d     = ISSUE;
        end
      end
      // An ACK seen here answers the checker's previous sample, so it is dropped.
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (chk_ack) begin
          capture = 1'b1;
`ifdef TIMEOUT_EN
        end else if (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          capture        = 1'b1;
          cap_code       = 3'b111;
          timeout_flag_d = 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    if (capture) begin
      res_data_d  = chk_data_q;
      res_exc_d   = cap_code;
      res_valid_d = 1'b1;
      chk_valid_d = 1'b0;
      state_d     = IDLE;
      if (cap_code == 3'b011 && inf_q != '1) inf_d = inf_q + 1'b1;
      if (cap_code == 3'b100 && nan_q != '1) nan_d = nan_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q     <= IDLE;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      chk_data_q  <= '0;
      chk_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_exc_q   <= '0;
      res_valid_q <= 1'b0;
      inf_q       <= '0;
      nan_q       <= '0;
`ifdef TIMEOUT_EN
      tmo_cnt_q      <= '0;
      timeout_flag_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      chk_data_q  <= chk_data_d;
      chk_valid_q <= chk_valid_d;
      res_data_q  <= res_data_d;
      res_exc_q   <= res_exc_d;
      res_valid_q <= res_valid_d;
      inf_q       <= inf_d;
      nan_q       <= nan_d;
`ifdef TIMEOUT_EN
      tmo_cnt_q      <= tmo_cnt_d;
      timeout_flag_q <= timeout_flag_d;
`endif
    end
  end

  assign in_ready  = !full;
  assign chk_data  = chk_data_q;
  assign chk_valid = chk_valid_q;
  assign res_data  = res_data_q;
  assign res_exc   = res_exc_q;
  assign res_valid = res_valid_q;
  assign inf_count = inf_q;
  assign nan_count = nan_q;
  assign busy      = !empty || (state_q != IDLE) || res_valid_q;
`ifdef TIMEOUT_EN
  assign timeout_flag = timeout_flag_q;
`endif

endmodule

// File: tb/tb_exc_check_requester.sv
// tb/tb_exc_check_requester.sv - directed, table-driven bench for exc_check_requester.
// Includes the watchdog sequence when TIMEOUT_EN is defined.
module tb_exc_check_requester;

  logic        CLK = 1'b0;
  logic        RSTN = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] chk_data;
  logic        chk_valid;
  logic        chk_ack;
  logic [2:0]  chk_exc;
  logic [31:0] res_data;
  logic [2:0]  res_exc;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [15:0] inf_count;
  logic [15:0] nan_count;
  logic        busy;
`ifdef TIMEOUT_EN
  logic        timeout_flag;
`endif

  exc_check_requester #(.DEPTH(4), .CNT_W(16), .TIMEOUT_CYCLES(15)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .chk_data(chk_data), .chk_valid(chk_valid), .chk_ack(chk_ack), .chk_exc(chk_exc),
    .res_data(res_data), .res_exc(res_exc), .res_valid(res_valid), .res_ready(res_ready),
    .inf_count(inf_count), .nan_count(nan_count), .busy(busy)
`ifdef TIMEOUT_EN
    , .timeout_flag(timeout_flag)
`endif
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Checker model: ACKs on the ack_delay-th negedge that sees chk_valid high.
  int          ack_delay = 3;
  bit          never_ack = 1'b0;
  bit          spurious = 1'b0;
  bit          ovr_en = 1'b0;
  logic [2:0]  ovr_exc = 3'b000;
  int          mcnt = 0;
  bit          mdone = 1'b0;
  logic        prev_v = 1'b0;
  logic [31:0] prev_d = '0;

  function automatic logic [2:0] classify(input logic [31:0] f);
    if (f[30:23] == 8'hFF && f[22:0] == 23'd0) return 3'b011;
    if (f[30:23] == 8'hFF) return 3'b100;
    return 3'b000;
  endfunction

  initial begin
    chk_ack = 1'b0;
    chk_exc = 3'b000;
    forever begin
      @(negedge CLK);
      chk_ack = 1'b0;
      if (prev_v && chk_valid) check("chk_data_stable", chk_data, prev_d);
      prev_v = chk_valid;
      prev_d = chk_data;
      if (!chk_valid) begin
        mcnt  = 0;
        mdone = 1'b0;
      end else if (!mdone) begin
        mcnt++;
        if (spurious && mcnt == 1) begin
          chk_ack = 1'b1;
          chk_exc = 3'b100;
        end else if (!never_ack && mcnt == ack_delay) begin
          chk_ack = 1'b1;
          chk_exc = ovr_en ? ovr_exc : classify(chk_data);
          mdone   = 1'b1;
        end
      end
    end
  end

  task automatic push_one(input logic [31:0] d);
    @(negedge CLK);
    in_data  = d;
    in_valid = 1'b1;
    @(posedge CLK);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_result(input int maxc, output int lat, output logic [31:0] d, output logic [2:0] e);
    lat = -1;
    d   = '0;
    e   = '0;
    for (int k = 1; k <= maxc; k++) begin
      @(posedge CLK);
      #1;
      if (res_valid) begin
        lat = k;
        d   = res_data;
        e   = res_exc;
        break;
      end
    end
  endtask

  logic [31:0] got_d [8];
  logic [2:0]  got_e [8];
  int          got_n;

  // Call at a negedge; samples res_valid before advancing.
  task automatic collect(input int n, input int maxc);
    got_n = 0;
    for (int k = 0; k < maxc && got_n < n; k++) begin
      if (res_valid) begin
        got_d[got_n] = res_data;
        got_e[got_n] = res_exc;
        got_n++;
      end
      @(negedge CLK);
    end
    check("collect_count", 32'(got_n), 32'(n));
  endtask

  typedef struct {
    logic [31:0] data;
    int          delay;
    bit          ovr;
    logic [2:0]  code;
    logic [2:0]  exp_exc;
    int          exp_lat;
  } vec_t;

  vec_t vecs [7];

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    int          lat;
    logic [31:0] d;
    logic [2:0]  e;
    int          acc;
    bit          take;
    int          seen;

    vecs[0] = '{32'h7F800000, 3, 1'b0, 3'b000, 3'b011, 4};
    vecs[1] = '{32'h7FC00000, 4, 1'b0, 3'b000, 3'b100, 5};
    vecs[2] = '{32'h3F800000, 3, 1'b0, 3'b000, 3'b000, 4};
    vecs[3] = '{32'hFF800000, 4, 1'b0, 3'b000, 3'b011, 5};
    vecs[4] = '{32'h7F800001, 3, 1'b0, 3'b000, 3'b100, 4};
    vecs[5] = '{32'h00000000, 4, 1'b0, 3'b000, 3'b000, 5};
    vecs[6] = '{32'h40490FDB, 3, 1'b1, 3'b010, 3'b010, 4};

    repeat (2) @(negedge CLK);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_chk_valid", 32'(chk_valid), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_counts", {inf_count, nan_count}, 32'd0);
`ifdef TIMEOUT_EN
    check("rst_timeout_flag", 32'(timeout_flag), 32'd0);
`endif
    RSTN = 1'b1;
    repeat (2) @(negedge CLK);

    for (int i = 0; i < 7; i++) begin
      ack_delay = vecs[i].delay;
      ovr_en    = vecs[i].ovr;
      ovr_exc   = vecs[i].code;
      push_one(vecs[i].data);
      wait_result(30, lat, d, e);
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("vec%0d_data", i), d, vecs[i].data);
      check($sformatf("vec%0d_exc", i), 32'(e), 32'(vecs[i].exp_exc));
      repeat (3) @(posedge CLK);
    end
    ovr_en = 1'b0;
    #1;
    check("table_inf_count", 32'(inf_count), 32'd2);
    check("table_nan_count", 32'(nan_count), 32'd2);
    check("table_idle_busy", 32'(busy), 32'd0);

    // Two back-to-back operands come back in order.
    ack_delay = 3;
    @(negedge CLK);
    in_data = 32'h7FC00000; in_valid = 1'b1;
    @(negedge CLK);
    in_data = 32'h3F800000;
    @(negedge CLK);
    in_valid = 1'b0;
    collect(2, 40);
    check("b2b_d0", got_d[0], 32'h7FC00000);
    check("b2b_e0", 32'(got_e[0]), 32'd4);
    check("b2b_d1", got_d[1], 32'h3F800000);
    check("b2b_e1", 32'(got_e[1]), 32'd0);
    check("b2b_nan_count", 32'(nan_count), 32'd3);

    // Backpressure: one word in the result slot plus four queued.
    res_ready = 1'b0;
    acc = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      in_data  = 32'h1000 + 32'(acc);
      in_valid = 1'b1;
      take     = in_ready;
      @(posedge CLK);
      if (take) acc++;
    end
    @(negedge CLK);
    in_valid = 1'b0;
    check("bp_accepted", 32'(acc), 32'd5);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_res_valid", 32'(res_valid), 32'd1);
    res_ready = 1'b1;
    collect(5, 200);
    for (int k = 0; k < 5; k++) check($sformatf("bp_order%0d", k), got_d[k], 32'h1000 + 32'(k));
    check("bp_drained_in_ready", 32'(in_ready), 32'd1);

    // ACK during ISSUE must be ignored.
    spurious  = 1'b1;
    ack_delay = 4;
    push_one(32'h3F800000);
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      if (chk_valid) begin
        seen = 1;
        break;
      end
    end
    check("issue_chk_valid_seen", 32'(seen), 32'd1);
    @(negedge CLK);
    check("issue_ack_ignored_valid", 32'(chk_valid), 32'd1);
    check("issue_ack_ignored_res", 32'(res_valid), 32'd0);
    collect(1, 20);
    check("issue_data", got_d[0], 32'h3F800000);
    check("issue_exc", 32'(got_e[0]), 32'd0);
    check("issue_nan_count", 32'(nan_count), 32'd3);
    spurious = 1'b0;
    repeat (2) @(negedge CLK);

    // Reset while waiting for ACK drops the operand and the queue.
    never_ack = 1'b1;
    ack_delay = 3;
    @(negedge CLK);
    in_data = 32'h7F800000; in_valid = 1'b1;
    @(negedge CLK);
    in_data = 32'h7FC00000;
    @(negedge CLK);
    in_valid = 1'b0;
    repeat (3) @(negedge CLK);
    check("rstwait_chk_valid", 32'(chk_valid), 32'd1);
    #2 RSTN = 1'b0;
    #1;
    check("rstwait_in_ready", 32'(in_ready), 32'd1);
    check("rstwait_chk_valid0", 32'(chk_valid), 32'd0);
    check("rstwait_chk_data", chk_data, 32'd0);
    check("rstwait_res", {29'd0, res_valid, res_exc[1:0]}, 32'd0);
    check("rstwait_res_data", res_data, 32'd0);
    check("rstwait_busy", 32'(busy), 32'd0);
    check("rstwait_counts", {inf_count, nan_count}, 32'd0);
    @(negedge CLK);
    never_ack = 1'b0;
    RSTN = 1'b1;
    seen = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge CLK);
      if (res_valid) seen++;
    end
    check("rstwait_no_result", 32'(seen), 32'd0);
    check("rstwait_idle_busy", 32'(busy), 32'd0);

    push_one(32'h7FC00000);
    wait_result(30, lat, d, e);
    check("postrst_lat", 32'(lat), 32'd4);
    check("postrst_exc", 32'(e), 32'd4);
    check("postrst_nan_count", 32'(nan_count), 32'd1);
    repeat (3) @(posedge CLK);

`ifdef TIMEOUT_EN
    never_ack = 1'b1;
    push_one(32'h7F800000);
    wait_result(40, lat, d, e);
    check("tmo_lat", 32'(lat), 32'd17);
    check("tmo_exc", 32'(e), 32'd7);
    check("tmo_data", d, 32'h7F800000);
    check("tmo_flag", 32'(timeout_flag), 32'd1);
    check("tmo_counts", {inf_count, nan_count}, {16'd0, 16'd1});
    never_ack = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("tmo_idle_busy", 32'(busy), 32'd0);
    check("tmo_flag_sticky", 32'(timeout_flag), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
